// File: rtl/downsampler_h_ctrl_fp16.sv
// -----------------------------------------------------------------------------
// downsampler_h_ctrl_fp16
//
// Frame-level sequencer for a 2-tap horizontal fp16 downsampling convolution
// (kernel [0.5, 0.5]). A raster pixel stream is paired into 1x2 windows made of
// columns (2k, 2k+1). One window per pair is issued to the convolution with the
// halved column coordinate. Results coming back from the convolution are
// counted so the frame is reported complete only once every issued window has
// returned.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   start_i             begin a frame; width_i/height_i are latched
//   width_i, height_i   frame size in pixels / rows
//   pixel_i, col_i,
//   row_i, valid_i      input raster pixel stream
//   window_o            [0][0] = even column pixel, [0][1] = odd column pixel
//   kernel_o            constant KERNEL_TAP on both taps
//   col_o, row_o        output window coordinate (column halved)
//   valid_o             one-cycle window strobe to the convolution
//   conv_valid_i        convolution result returned
//   busy_o              frame in progress (ACTIVE or FLUSH)
//   done_o              one-cycle frame-complete pulse
//   err_o               sticky error, cleared by an accepted start_i
//   inflight_o          number of windows issued but not yet returned
// -----------------------------------------------------------------------------
module downsampler_h_ctrl_fp16 #(
    parameter int                      EXP_WIDTH    = 5,
    parameter int                      FRAC_WIDTH   = 10,
    parameter int                      FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
    parameter logic [FP_WIDTH_REG-1:0] KERNEL_TAP   = 16'h3800,
    parameter int                      INFLIGHT_W   = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 start_i,
    input  logic [15:0]                          width_i,
    input  logic [15:0]                          height_i,
    input  logic [FP_WIDTH_REG-1:0]              pixel_i,
    input  logic [15:0]                          col_i,
    input  logic [15:0]                          row_i,
    input  logic                                 valid_i,
    output logic [0:0][1:0][FP_WIDTH_REG-1:0]    window_o,
    output logic [0:0][1:0][FP_WIDTH_REG-1:0]    kernel_o,
    output logic [15:0]                          col_o,
    output logic [15:0]                          row_o,
    output logic                                 valid_o,
    input  logic                                 conv_valid_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 err_o,
    output logic [INFLIGHT_W-1:0]                inflight_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    localparam logic [INFLIGHT_W-1:0] INFL_ZERO = {INFLIGHT_W{1'b0}};
    localparam logic [INFLIGHT_W-1:0] INFL_ONE  = {{(INFLIGHT_W-1){1'b0}}, 1'b1};
    localparam logic [INFLIGHT_W-1:0] INFL_MAX  = {INFLIGHT_W{1'b1}};

    state_e                              state_q, state_d;
    logic [15:0]                         width_q, width_d;
    logic [15:0]                         height_q, height_d;
    logic [FP_WIDTH_REG-1:0]             cap_pix_q, cap_pix_d;
    logic [15:0]                         cap_col_q, cap_col_d;
    logic [15:0]                         cap_row_q, cap_row_d;
    logic                                cap_vld_q, cap_vld_d;
    logic [0:0][1:0][FP_WIDTH_REG-1:0]   window_q, window_d;
    logic [15:0]                         col_q, col_d;
    logic [15:0]                         row_q, row_d;
    logic                                valid_q, valid_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;
    logic                                err_q, err_d;
    logic [INFLIGHT_W-1:0]               inflight_q, inflight_d;

    logic                                in_range_s;
    logic                                last_s;
    logic                                pair_ok_s;
    logic                                trail_ok_s;
    logic                                issue_s;

    // Next-state, pairing datapath and outstanding-window counter.
    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        height_d   = height_q;
        cap_pix_d  = cap_pix_q;
        cap_col_d  = cap_col_q;
        cap_row_d  = cap_row_q;
        cap_vld_d  = cap_vld_q;
        window_d   = window_q;
        col_d      = col_q;
        row_d      = row_q;
        valid_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        inflight_d = inflight_q;
        issue_s    = 1'b0;

        in_range_s = (col_i < width_q) && (row_i < height_q);
        last_s     = in_range_s && (col_i == width_q - 16'd1) && (row_i == height_q - 16'd1);
        pair_ok_s  = cap_vld_q && (cap_col_q == col_i - 16'd1) && (cap_row_q == row_i);
        // A leftover capture of the final column of an odd-width row is
        // expected to be overwritten by column 0 of the next row.
        trail_ok_s = width_q[0] && (cap_col_q == width_q - 16'd1);

        // Pixel pairing while a frame is streaming.
        if ((state_q == ST_ACTIVE) && valid_i) begin
            if (!in_range_s) begin
                err_d = 1'b1;
            end else begin
                if (col_i[0] == 1'b0) begin
                    if (cap_vld_q && !trail_ok_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    cap_pix_d = pixel_i;
                    cap_col_d = col_i;
                    cap_row_d = row_i;
                    cap_vld_d = 1'b1;
                end else begin
                    if (pair_ok_s) begin
                        issue_s        = 1'b1;
                        valid_d        = 1'b1;
                        window_d[0][0] = cap_pix_q;
                        window_d[0][1] = pixel_i;
                        col_d          = {1'b0, col_i[15:1]};
                        row_d          = row_i;
                    end else begin
                        err_d = 1'b1;
                    end
                    cap_vld_d = 1'b0;
                end
                // The frame's final pixel ends streaming; an unpaired even
                // capture (odd width) is simply dropped.
                if (last_s) begin
                    state_d   = ST_FLUSH;
                    cap_vld_d = 1'b0;
                end else begin
                    state_d   = ST_ACTIVE;
                end
            end
        end else begin
            issue_s = 1'b0;
        end

        // Outstanding count: simultaneous issue and return cancel out.
        if (issue_s && !conv_valid_i) begin
            if (inflight_q == INFL_MAX) begin
                err_d = 1'b1;
            end else begin
                inflight_d = inflight_q + INFL_ONE;
            end
        end else if (!issue_s && conv_valid_i) begin
            if (inflight_q == INFL_ZERO) begin
                err_d = 1'b1;
            end else begin
                inflight_d = inflight_q - INFL_ONE;
            end
        end else begin
            inflight_d = inflight_q;
        end

        // Frame start and completion.
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    width_d    = width_i;
                    height_d   = height_i;
                    err_d      = 1'b0;
                    inflight_d = INFL_ZERO;
                    cap_vld_d  = 1'b0;
                    if ((width_i == 16'd0) || (height_i == 16'd0)) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                // Transitions out of ACTIVE are decided by the pairing logic.
                done_d = 1'b0;
            end
            ST_FLUSH: begin
                // Using the updated count lets the last return finish the frame
                // in the same cycle it arrives.
                if (inflight_d == INFL_ZERO) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            width_q    <= 16'd0;
            height_q   <= 16'd0;
            cap_pix_q  <= {FP_WIDTH_REG{1'b0}};
            cap_col_q  <= 16'd0;
            cap_row_q  <= 16'd0;
            cap_vld_q  <= 1'b0;
            window_q   <= {(2*FP_WIDTH_REG){1'b0}};
            col_q      <= 16'd0;
            row_q      <= 16'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            inflight_q <= INFL_ZERO;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            height_q   <= height_d;
            cap_pix_q  <= cap_pix_d;
            cap_col_q  <= cap_col_d;
            cap_row_q  <= cap_row_d;
            cap_vld_q  <= cap_vld_d;
            window_q   <= window_d;
            col_q      <= col_d;
            row_q      <= row_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            inflight_q <= inflight_d;
        end
    end

    assign window_o       = window_q;
    assign kernel_o[0][0] = KERNEL_TAP;
    assign kernel_o[0][1] = KERNEL_TAP;
    assign col_o          = col_q;
    assign row_o          = row_q;
    assign valid_o        = valid_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign inflight_o     = inflight_q;

endmodule

// File: tb/tb_downsampler_h_ctrl_fp16.sv
module tb_downsampler_h_ctrl_fp16;

    typedef struct packed {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] col;
        logic [15:0] row;
    } exp_t;

    logic                    clk_i = 1'b0;
    logic                    rst_i = 1'b0;
    logic                    start_i = 1'b0;
    logic [15:0]             width_i = 16'd0;
    logic [15:0]             height_i = 16'd0;
    logic [15:0]             pixel_i = 16'd0;
    logic [15:0]             col_i = 16'd0;
    logic [15:0]             row_i = 16'd0;
    logic                    valid_i = 1'b0;
    logic [0:0][1:0][15:0]   window_o;
    logic [0:0][1:0][15:0]   kernel_o;
    logic [15:0]             col_o;
    logic [15:0]             row_o;
    logic                    valid_o;
    logic                    conv_valid_i;
    logic                    busy_o;
    logic                    done_o;
    logic                    err_o;
    logic [3:0]              inflight_o;

    logic                    man_conv = 1'b0;
    logic                    auto_en = 1'b0;
    logic [2:0]              ret_pipe;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    int   win_cnt = 0;

    downsampler_h_ctrl_fp16 dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .width_i      (width_i),
        .height_i     (height_i),
        .pixel_i      (pixel_i),
        .col_i        (col_i),
        .row_i        (row_i),
        .valid_i      (valid_i),
        .window_o     (window_o),
        .kernel_o     (kernel_o),
        .col_o        (col_o),
        .row_o        (row_o),
        .valid_o      (valid_o),
        .conv_valid_i (conv_valid_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .inflight_o   (inflight_o)
    );

    always #5 clk_i = ~clk_i;

    // Convolution model: returns each window three cycles after it is seen.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) ret_pipe <= 3'b000;
        else        ret_pipe <= {ret_pipe[1:0], valid_o & auto_en};
    end
    assign conv_valid_i = ret_pipe[2] | man_conv;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] pval(input logic [15:0] c, input logic [15:0] r);
        return 16'h1000 + (r * 16'd64) + c;
    endfunction

    // One clock; afterwards score any window the DUT presents.
    task automatic tick();
        exp_t e;
        @(posedge clk_i);
        #1;
        if (done_o) done_cnt++;
        if (valid_o) begin
            win_cnt++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_window: got col=%0d row=%0d, required no window", col_o, row_o);
            end else begin
                e = sb_q.pop_front();
                if ({window_o[0][0], window_o[0][1], col_o, row_o} !== {e.w0, e.w1, e.col, e.row}) begin
                    errors++;
                    $display("FAIL window: got %h,%h col=%0d row=%0d, required %h,%h col=%0d row=%0d",
                             window_o[0][0], window_o[0][1], col_o, row_o, e.w0, e.w1, e.col, e.row);
                end
            end
        end
    endtask

    task automatic pix(input logic [15:0] c, input logic [15:0] r, input logic pair);
        exp_t e;
        col_i   = c;
        row_i   = r;
        pixel_i = pval(c, r);
        valid_i = 1'b1;
        if (pair) begin
            e.w0  = pval(c - 16'd1, r);
            e.w1  = pval(c, r);
            e.col = c / 16'd2;
            e.row = r;
            sb_q.push_back(e);
        end
        tick();
        valid_i = 1'b0;
    endtask

    task automatic send_row(input logic [15:0] r, input int n);
        for (int c = 0; c < n; c++) pix(16'(c), r, (c % 2) == 1);
    endtask

    task automatic start_frame(input logic [15:0] w, input logic [15:0] h);
        start_i  = 1'b1;
        width_i  = w;
        height_i = h;
        tick();
        start_i  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL %s_done_timeout: got no done_o in %0d cycles, required one", name, budget);
        end else begin
            checks++;
            if (inflight_o !== 4'd0) begin
                errors++;
                $display("FAIL %s_inflight_at_done: got %0d, required 0", name, inflight_o);
            end
        end
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (done_cnt !== d0 + 1) begin
            errors++;
            $display("FAIL %s_done_count: got %0d, required %0d", name, done_cnt - d0, 1);
        end
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL %s_missing_windows: got %0d left, required 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        tick();
        tick();
        checks++;
        if ({valid_o, busy_o, done_o, err_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 0000", {valid_o, busy_o, done_o, err_o});
        end
        checks++;
        if ({inflight_o, col_o, row_o, window_o} !== 68'd0) begin
            errors++;
            $display("FAIL reset_data: got infl=%0d col=%0d row=%0d win=%h, required all 0",
                     inflight_o, col_o, row_o, window_o);
        end
        checks++;
        if (kernel_o[0][0] !== 16'h3800 || kernel_o[0][1] !== 16'h3800) begin
            errors++;
            $display("FAIL kernel: got %h,%h, required 3800,3800", kernel_o[0][0], kernel_o[0][1]);
        end
        rst_i = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int w0 = win_cnt;
        auto_en = 1'b1;
        start_frame(16'd4, 16'd2);
        send_row(16'd0, 4);
        send_row(16'd1, 4);
        wait_done("basic", 60);
        checks++;
        if (win_cnt - w0 !== 4) begin
            errors++;
            $display("FAIL basic_windows: got %0d, required 4", win_cnt - w0);
        end
        checks++;
        if ({err_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL basic_err_busy: got %b, required 00", {err_o, busy_o});
        end
    endtask

    task automatic test_odd_width();
        int w0 = win_cnt;
        start_frame(16'd5, 16'd1);
        send_row(16'd0, 5);
        wait_done("odd_width", 60);
        checks++;
        if (win_cnt - w0 !== 2) begin
            errors++;
            $display("FAIL odd_width_windows: got %0d, required 2", win_cnt - w0);
        end
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL odd_width_err: got %b, required 0", err_o);
        end
    endtask

    task automatic test_missing_even();
        int w0 = win_cnt;
        start_frame(16'd4, 16'd1);
        pix(16'd0, 16'd0, 1'b0);
        pix(16'd1, 16'd0, 1'b1);
        pix(16'd3, 16'd0, 1'b0);
        wait_done("missing_even", 60);
        checks++;
        if (win_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL missing_even_windows: got %0d, required 1", win_cnt - w0);
        end
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL missing_even_err: got %b, required 1", err_o);
        end
    endtask

    task automatic test_inflight();
        auto_en = 1'b0;
        start_frame(16'd8, 16'd1);
        for (int c = 0; c < 4; c++) pix(16'(c), 16'd0, (c % 2) == 1);
        checks++;
        if (inflight_o !== 4'd2) begin
            errors++;
            $display("FAIL inflight_two: got %0d, required 2", inflight_o);
        end
        pix(16'd4, 16'd0, 1'b0);
        man_conv = 1'b1;
        pix(16'd5, 16'd0, 1'b1);
        man_conv = 1'b0;
        checks++;
        if ({inflight_o, err_o} !== {4'd2, 1'b0}) begin
            errors++;
            $display("FAIL inflight_cancel: got infl=%0d err=%b, required infl=2 err=0", inflight_o, err_o);
        end
        man_conv = 1'b1;
        tick();
        tick();
        man_conv = 1'b0;
        checks++;
        if (inflight_o !== 4'd0) begin
            errors++;
            $display("FAIL inflight_drain: got %0d, required 0", inflight_o);
        end
        man_conv = 1'b1;
        tick();
        man_conv = 1'b0;
        checks++;
        if ({inflight_o, err_o} !== {4'd0, 1'b1}) begin
            errors++;
            $display("FAIL inflight_underflow: got infl=%0d err=%b, required infl=0 err=1", inflight_o, err_o);
        end
        pix(16'd6, 16'd0, 1'b0);
        pix(16'd7, 16'd0, 1'b1);
        checks++;
        if ({inflight_o, busy_o, done_o} !== {4'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL inflight_flush: got infl=%0d busy=%b done=%b, required 1,1,0", inflight_o, busy_o, done_o);
        end
        man_conv = 1'b1;
        tick();
        man_conv = 1'b0;
        checks++;
        if ({done_o, inflight_o} !== {1'b1, 4'd0}) begin
            errors++;
            $display("FAIL inflight_done_on_return: got done=%b infl=%0d, required 1,0", done_o, inflight_o);
        end
        tick();
        checks++;
        if ({done_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL inflight_done_pulse: got done=%b busy=%b, required 0,0", done_o, busy_o);
        end
    endtask

    task automatic test_zero_width();
        int d0;
        start_i  = 1'b1;
        width_i  = 16'd0;
        height_i = 16'd3;
        tick();
        checks++;
        if ({done_o, busy_o} !== 2'b01) begin
            errors++;
            $display("FAIL zero_w_first: got done=%b busy=%b, required 0,1", done_o, busy_o);
        end
        // Start coincides with the done cycle and must be ignored.
        width_i  = 16'd4;
        height_i = 16'd1;
        tick();
        checks++;
        if ({done_o, busy_o} !== 2'b10) begin
            errors++;
            $display("FAIL zero_w_done: got done=%b busy=%b, required 1,0", done_o, busy_o);
        end
        tick();
        start_i = 1'b0;
        checks++;
        if ({done_o, busy_o} !== 2'b01) begin
            errors++;
            $display("FAIL start_after_done: got done=%b busy=%b, required 0,1", done_o, busy_o);
        end
        auto_en = 1'b1;
        start_frame(16'd2, 16'd1);
        d0 = done_cnt;
        pix(16'd0, 16'd0, 1'b0);
        pix(16'd1, 16'd0, 1'b1);
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if ({busy_o, inflight_o} !== {1'b1, 4'd0} || done_cnt !== d0) begin
            errors++;
            $display("FAIL start_in_active: got busy=%b infl=%0d dones=%0d, required busy=1 infl=0 dones=0",
                     busy_o, inflight_o, done_cnt - d0);
        end
        pix(16'd2, 16'd0, 1'b0);
        pix(16'd3, 16'd0, 1'b1);
        wait_done("width_latch", 60);
    endtask

    task automatic test_reset_mid();
        int d0;
        auto_en = 1'b0;
        start_frame(16'd8, 16'd2);
        for (int c = 0; c < 7; c++) pix(16'(c), 16'd0, (c % 2) == 1);
        checks++;
        if (inflight_o !== 4'd3) begin
            errors++;
            $display("FAIL mid_inflight: got %0d, required 3", inflight_o);
        end
        d0 = done_cnt;
        #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if ({valid_o, busy_o, done_o, err_o, inflight_o, col_o, row_o, window_o} !== 72'd0) begin
            errors++;
            $display("FAIL mid_async_reset: got busy=%b infl=%0d col=%0d row=%0d win=%h, required all 0",
                     busy_o, inflight_o, col_o, row_o, window_o);
        end
        tick();
        rst_i = 1'b1;
        tick();
        man_conv = 1'b1;
        tick();
        man_conv = 1'b0;
        checks++;
        if ({err_o, inflight_o, busy_o} !== {1'b1, 4'd0, 1'b0} || done_cnt !== d0) begin
            errors++;
            $display("FAIL stale_return: got err=%b infl=%0d busy=%b dones=%0d, required 1,0,0,0",
                     err_o, inflight_o, busy_o, done_cnt - d0);
        end
        start_frame(16'd2, 16'd1);
        checks++;
        if ({err_o, busy_o} !== 2'b01) begin
            errors++;
            $display("FAIL restart_clears_err: got err=%b busy=%b, required 0,1", err_o, busy_o);
        end
        auto_en = 1'b1;
        pix(16'd0, 16'd0, 1'b0);
        pix(16'd1, 16'd0, 1'b1);
        wait_done("after_reset", 60);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd_width();
        test_missing_even();
        test_inflight();
        test_zero_width();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
